// File: rtl/mesh_lock_sequencer.sv
// Bring-up and lock supervision sequencer for an N-node ADPLL mesh.
// Optional feature: define MESH_SEQ_RELOCK_EN to re-acquire lost nodes instead of failing.
module mesh_lock_sequencer #(
    parameter int N_NODES     = 4,
    parameter int PDET_WIDTH  = 5,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int TIMEOUT     = 65536,
    parameter int CNT_WIDTH   = 17
) (
    input  logic                          fpga_clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [N_NODES*PDET_WIDTH-1:0] error_i,
    input  logic [3:0]                    kp_acq_i,
    input  logic [3:0]                    ki_acq_i,
    input  logic [3:0]                    kp_trk_i,
    input  logic [3:0]                    ki_trk_i,
    output logic [N_NODES-1:0]            enable_o,
    output logic                          uni_dir_o,
    output logic [3:0]                    kp_o,
    output logic [3:0]                    ki_o,
    output logic [N_NODES-1:0]            locked_o,
    output logic [2:0]                    node_o,
    output logic [1:0]                    state_o,
    output logic                          fail_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2, FAIL = 2'd3} state_t;

    localparam logic [PDET_WIDTH:0]  THRESH_W  = (PDET_WIDTH+1)'(LOCK_THRESH);
    localparam logic [CNT_WIDTH-1:0] LOCK_CNT  = CNT_WIDTH'(LOCK_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_W = CNT_WIDTH'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [N_NODES-1:0]     enable_q, enable_d, locked_q, locked_d, lock_raw, in_thresh;
    logic [CNT_WIDTH-1:0]   lock_cnt_q [N_NODES];
    logic [CNT_WIDTH-1:0]   lock_cnt_d [N_NODES];
    logic [CNT_WIDTH-1:0]   lock_cnt_raw [N_NODES];
    logic [CNT_WIDTH-1:0]   tmo_q, tmo_d;
    logic [2:0]             node_q, node_d, next_up;
    logic [N_NODES-1:0]     next_mask;
    logic                   found_up, rise;
    logic [3:0]             kp_q, kp_d, ki_q, ki_d;
    logic                   uni_dir_q, uni_dir_d, fail_q, fail_d;
    logic [PDET_WIDTH-1:0]  err_mag [N_NODES];
`ifdef MESH_SEQ_RELOCK_EN
    logic [2:0]             lowest_unlocked;
`endif

    // Magnitude kept unsigned so the most negative sample maps to 2^(W-1).
    for (genvar gi = 0; gi < N_NODES; gi++) begin : g_mag
        logic [PDET_WIDTH-1:0] err;
        assign err           = error_i[gi*PDET_WIDTH +: PDET_WIDTH];
        assign err_mag[gi]   = err[PDET_WIDTH-1] ? (~err + 1'b1) : err;
        assign in_thresh[gi] = ({1'b0, err_mag[gi]} <= THRESH_W);
    end

    // Each counter tallies samples that disagree with the current lock flag.
    always_comb begin
        for (int k = 0; k < N_NODES; k++) begin
            lock_raw[k]     = locked_q[k];
            lock_cnt_raw[k] = '0;
            if (abort_i || !enable_q[k]) begin
                lock_raw[k] = 1'b0;
            end else if (locked_q[k] != in_thresh[k]) begin
                if (lock_cnt_q[k] + 1'b1 == LOCK_CNT) begin
                    lock_raw[k] = ~locked_q[k];
                end else begin
                    lock_cnt_raw[k] = lock_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise      = 1'b0;
        found_up  = 1'b0;
        next_up   = '0;
        next_mask = '0;
        for (int k = N_NODES - 1; k >= 0; k--) begin
            if (3'(k) == node_q) rise = lock_raw[k] & ~locked_q[k];
            if (3'(k) > node_q && !lock_raw[k]) begin
                found_up  = 1'b1;
                next_up   = 3'(k);
                next_mask = N_NODES'(1) << k;
            end
        end
`ifdef MESH_SEQ_RELOCK_EN
        lowest_unlocked = '0;
        for (int k = N_NODES - 1; k >= 0; k--) begin
            if (!lock_raw[k]) lowest_unlocked = 3'(k);
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        node_d   = node_q;
        tmo_d    = '0;
        case (state_q)
            IDLE, FAIL: begin
                enable_d = '0;
                if (start_i) begin
                    state_d  = ACQUIRE;
                    node_d   = '0;
                    enable_d = N_NODES'(1);
                end
            end
            ACQUIRE: begin
                tmo_d = tmo_q + 1'b1;
                if (rise) begin
                    tmo_d = '0;
                    if (found_up) begin
                        node_d   = next_up;
                        enable_d = enable_q | next_mask;
                    end else begin
                        state_d  = TRACK;
                        enable_d = '1;
                    end
                end else if (tmo_d == TIMEOUT_W) begin
                    state_d  = FAIL;
                    enable_d = '0;
                end
            end
            default: begin
                enable_d = '1;
                if (!(&lock_raw)) begin
`ifdef MESH_SEQ_RELOCK_EN
                    state_d = ACQUIRE;
                    node_d  = lowest_unlocked;
`else
                    state_d  = FAIL;
                    enable_d = '0;
`endif
                end
            end
        endcase
        if (abort_i) begin
            state_d  = IDLE;
            enable_d = '0;
            node_d   = '0;
            tmo_d    = '0;
        end

        kp_d      = '0;
        ki_d      = '0;
        uni_dir_d = 1'b1;
        fail_d    = 1'b0;
        case (state_d)
            ACQUIRE: begin kp_d = kp_acq_i; ki_d = ki_acq_i; end
            TRACK:   begin kp_d = kp_trk_i; ki_d = ki_trk_i; uni_dir_d = 1'b0; end
            FAIL:    fail_d = 1'b1;
            default: ;
        endcase

        locked_d = lock_raw & enable_d;
        for (int k = 0; k < N_NODES; k++) begin
            lock_cnt_d[k] = enable_d[k] ? lock_cnt_raw[k] : '0;
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            enable_q  <= '0;
            locked_q  <= '0;
            tmo_q     <= '0;
            node_q    <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            uni_dir_q <= 1'b1;
            fail_q    <= 1'b0;
            for (int k = 0; k < N_NODES; k++) lock_cnt_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            locked_q  <= locked_d;
            tmo_q     <= tmo_d;
            node_q    <= node_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            uni_dir_q <= uni_dir_d;
            fail_q    <= fail_d;
            for (int k = 0; k < N_NODES; k++) lock_cnt_q[k] <= lock_cnt_d[k];
        end
    end

    assign enable_o  = enable_q;
    assign locked_o  = locked_q;
    assign node_o    = node_q;
    assign kp_o      = kp_q;
    assign ki_o      = ki_q;
    assign uni_dir_o = uni_dir_q;
    assign fail_o    = fail_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_mesh_lock_sequencer.sv
// Directed bench for mesh_lock_sequencer with short lock/timeout windows.
module tb_mesh_lock_sequencer;
    localparam int N  = 4;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          reset_i, start_i, abort_i;
    logic [N*PW-1:0] error_i;
    logic [3:0]    kp_acq_i, ki_acq_i, kp_trk_i, ki_trk_i;
    logic [N-1:0]  enable_o, locked_o;
    logic          uni_dir_o, fail_o;
    logic [3:0]    kp_o, ki_o;
    logic [2:0]    node_o;
    logic [1:0]    state_o;

    int tests_run = 0;
    int tests_failed = 0;

    mesh_lock_sequencer #(
        .N_NODES(N), .PDET_WIDTH(PW), .LOCK_THRESH(2),
        .LOCK_CYCLES(8), .TIMEOUT(64), .CNT_WIDTH(17)
    ) dut (
        .fpga_clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
        .error_i(error_i), .kp_acq_i(kp_acq_i), .ki_acq_i(ki_acq_i),
        .kp_trk_i(kp_trk_i), .ki_trk_i(ki_trk_i), .enable_o(enable_o),
        .uni_dir_o(uni_dir_o), .kp_o(kp_o), .ki_o(ki_o), .locked_o(locked_o),
        .node_o(node_o), .state_o(state_o), .fail_o(fail_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_err(input int k, input logic [PW-1:0] v);
        error_i[k*PW +: PW] = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; error_i = '0;
        kp_acq_i = 4'd3; ki_acq_i = 4'd5; kp_trk_i = 4'd9; ki_trk_i = 4'd12;
        tick(2);
        reset_i = 1'b0;
        check("rst_enable", 32'(enable_o), 32'h0);
        check("rst_state",  32'(state_o),  32'h0);
        check("rst_uni",    32'(uni_dir_o), 32'h1);
        check("rst_kp",     32'(kp_o), 32'h0);
        check("rst_ki",     32'(ki_o), 32'h0);
        check("rst_fail",   32'(fail_o), 32'h0);
        check("rst_locked", 32'(locked_o), 32'h0);

        // Full bring-up with clean errors.
        start_i = 1'b1; tick(1); start_i = 1'b0;
        check("acq_en0",   32'(enable_o), 32'b0001);
        check("acq_state", 32'(state_o), 32'h1);
        check("acq_kp",    32'(kp_o), 32'h3);
        check("acq_ki",    32'(ki_o), 32'h5);
        check("acq_uni",   32'(uni_dir_o), 32'h1);
        tick(7);
        check("en0_hold",  32'(enable_o), 32'b0001);
        tick(1);
        check("en1",       32'(enable_o), 32'b0011);
        check("node1",     32'(node_o), 32'h1);
        check("lock0",     32'(locked_o), 32'b0001);
        tick(8);
        check("en2",       32'(enable_o), 32'b0111);
        check("node2",     32'(node_o), 32'h2);
        tick(8);
        check("en3",       32'(enable_o), 32'b1111);
        check("node3",     32'(node_o), 32'h3);
        check("state_acq3", 32'(state_o), 32'h1);
        tick(8);
        check("trk_state", 32'(state_o), 32'h2);
        check("trk_uni",   32'(uni_dir_o), 32'h0);
        check("trk_kp",    32'(kp_o), 32'h9);
        check("trk_ki",    32'(ki_o), 32'hC);
        check("trk_locked", 32'(locked_o), 32'b1111);
        kp_trk_i = 4'd7; tick(1);
        check("gain_lat",  32'(kp_o), 32'h7);

        // Loss of lock on node 1 with the most negative error.
        set_err(1, 5'b10000);
        start_i = 1'b1;
        tick(7);
        check("loss_hold_locked", 32'(locked_o), 32'b1111);
        check("loss_hold_state",  32'(state_o), 32'h2);
        tick(1);
        start_i = 1'b0;
`ifdef MESH_SEQ_RELOCK_EN
        check("loss_state",  32'(state_o), 32'h1);
        check("loss_node",   32'(node_o), 32'h1);
        check("loss_enable", 32'(enable_o), 32'b1111);
        check("loss_locked", 32'(locked_o), 32'b1101);
        check("loss_kp",     32'(kp_o), 32'h3);
`else
        check("loss_state",  32'(state_o), 32'h3);
        check("loss_enable", 32'(enable_o), 32'b0000);
        check("loss_fail",   32'(fail_o), 32'h1);
        check("loss_locked", 32'(locked_o), 32'b0000);
`endif
        set_err(1, 5'd0);
        abort_i = 1'b1; tick(1); abort_i = 1'b0;
        check("abort_state",  32'(state_o), 32'h0);
        check("abort_enable", 32'(enable_o), 32'h0);
        check("abort_locked", 32'(locked_o), 32'h0);
        check("abort_fail",   32'(fail_o), 32'h0);

        // Node 2 never settles: timeout 64 cycles after it is enabled.
        set_err(2, 5'd5);
        start_i = 1'b1; tick(1); start_i = 1'b0;
        tick(16);
        check("to_en2",    32'(enable_o), 32'b0111);
        tick(63);
        check("to_pre",    32'(state_o), 32'h1);
        tick(1);
        check("to_state",  32'(state_o), 32'h3);
        check("to_enable", 32'(enable_o), 32'h0);
        check("to_fail",   32'(fail_o), 32'h1);
        check("to_locked", 32'(locked_o), 32'h0);
        check("to_kp",     32'(kp_o), 32'h0);

        // Restart from FAIL; node 0 alternates 0 and 3 so it never locks.
        set_err(2, 5'd0);
        start_i = 1'b1; tick(1); start_i = 1'b0;
        check("rs_state",  32'(state_o), 32'h1);
        check("rs_enable", 32'(enable_o), 32'b0001);
        check("rs_fail",   32'(fail_o), 32'h0);
        for (int i = 0; i < 63; i++) begin
            set_err(0, (i % 2 == 0) ? 5'd3 : 5'd0);
            tick(1);
        end
        check("alt_locked", 32'(locked_o), 32'h0);
        check("alt_pre",    32'(state_o), 32'h1);
        set_err(0, 5'd3);
        tick(1);
        check("alt_state",  32'(state_o), 32'h3);

        // start ignored in ACQUIRE; abort wins over start.
        set_err(0, 5'd0);
        start_i = 1'b1; tick(3);
        check("ign_state",  32'(state_o), 32'h1);
        check("ign_enable", 32'(enable_o), 32'b0001);
        abort_i = 1'b1; tick(1);
        check("prio_state",  32'(state_o), 32'h0);
        check("prio_enable", 32'(enable_o), 32'h0);
        check("prio_uni",    32'(uni_dir_o), 32'h1);
        start_i = 1'b0; abort_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
